// File: rtl/uart_rx_fifo_receiver.sv
// UART receiver on the system clock: synchronizer, 3-sample majority vote per bit,
// optional parity / stop checking, and a show-ahead FIFO of {data, perr, ferr}.
module uart_rx_fifo_receiver #(
    parameter int DIV        = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          UART_RX,
    input  logic                          RX_RD,
    input  logic                          CLR_OVR,
    output logic [DATA_BITS-1:0]          RX_DATA,
    output logic                          RX_PERR,
    output logic                          RX_FERR,
    output logic                          RX_STATUS,
    output logic [$clog2(FIFO_DEPTH):0]   RX_COUNT,
    output logic                          OVERRUN
);
    localparam int CW   = $clog2(DIV);
    localparam int M    = DIV / 2;
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam int EW   = DATA_BITS + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_idx, bit_nxt;
    logic                 stop_idx, stop_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 perr, perr_nxt, ferr, ferr_nxt;
    logic                 sync0, sync1, rx_prev;
    logic                 samp_a, samp_b;
    logic                 fall, vote, at_mid, at_end, push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0   <= 1'b1;
            sync1   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync0   <= UART_RX;
            sync1   <= sync0;
            rx_prev <= sync1;
        end
    end

    assign fall   = rx_prev & ~sync1;
    assign at_mid = (cnt == CW'(M + 1));
    assign at_end = (cnt == CW'(DIV - 1));
    // Third sample is the live synchronized line at cnt = M+1.
    assign vote   = (samp_a & samp_b) | (samp_a & sync1) | (samp_b & sync1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_nxt;
            stop_idx <= stop_nxt;
            shreg    <= shreg_nxt;
            perr     <= perr_nxt;
            ferr     <= ferr_nxt;
            if (cnt == CW'(M - 1)) samp_a <= sync1;
            if (cnt == CW'(M))     samp_b <= sync1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        stop_nxt  = stop_idx;
        shreg_nxt = shreg;
        perr_nxt  = perr;
        ferr_nxt  = ferr;
        push      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (fall) begin
                    state_nxt = START;
                    perr_nxt  = 1'b0;
                    ferr_nxt  = 1'b0;
                end
            end
            START: begin
                if (at_mid && vote) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (at_end) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (at_mid) shreg_nxt = {vote, shreg[DATA_BITS-1:1]};
                if (at_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        state_nxt = (PARITY != 0) ? PAR : STOP;
                        stop_nxt  = 1'b0;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end
            end
            PAR: begin
                if (at_mid) perr_nxt = vote ^ (^shreg) ^ (PARITY == 1);
                if (at_end) begin
                    state_nxt = STOP;
                    cnt_nxt   = '0;
                    stop_nxt  = 1'b0;
                end
            end
            STOP: begin
                if (at_mid) begin
                    if (!vote) ferr_nxt = 1'b1;
                    // Push mid-way through the last stop bit so the next start edge is not missed.
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (at_end) begin
                    cnt_nxt  = '0;
                    stop_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          full, empty, pop_ok, push_ok, drop;
    logic [EW-1:0] push_word, head;

    assign full      = (count == NW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign pop_ok    = RX_RD & ~empty;
    assign push_ok   = push & (~full | pop_ok);
    assign drop      = push & full & ~pop_ok;
    assign push_word = {shreg, perr, ferr | ~vote};

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            OVERRUN <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear wins.
            if (drop)         OVERRUN <= 1'b1;
            else if (CLR_OVR) OVERRUN <= 1'b0;
        end
    end

    assign head      = mem[rd_ptr];
    assign RX_STATUS = ~empty;
    assign RX_COUNT  = count;
    assign RX_DATA   = empty ? '0 : head[EW-1:2];
    assign RX_PERR   = (PARITY != 0) ? (head[1] & ~empty) : 1'b0;
    assign RX_FERR   = head[0] & ~empty;

endmodule

// File: tb/tb_uart_rx_fifo_receiver.sv
// Directed bench: frames are driven bit by bit, expected entries queued at send time,
// and monitors compare the head entry whenever a read strobe pops it.
module tb_uart_rx_fifo_receiver;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic reset;
    logic rx0, rx1, rd0, rd1, clr0, clr1;
    logic [7:0] d0;
    logic [6:0] d1;
    logic perr0, ferr0, st0, ovr0, perr1, ferr1, st1, ovr1;
    logic [2:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    always #5 clk = ~clk;

    uart_rx_fifo_receiver #(.DIV(DIV)) dut0 (
        .clk(clk), .reset(reset), .UART_RX(rx0), .RX_RD(rd0), .CLR_OVR(clr0),
        .RX_DATA(d0), .RX_PERR(perr0), .RX_FERR(ferr0), .RX_STATUS(st0),
        .RX_COUNT(cnt0), .OVERRUN(ovr0));

    uart_rx_fifo_receiver #(.DIV(DIV), .DATA_BITS(7), .PARITY(2)) dut1 (
        .clk(clk), .reset(reset), .UART_RX(rx1), .RX_RD(rd1), .CLR_OVR(clr1),
        .RX_DATA(d1), .RX_PERR(perr1), .RX_FERR(ferr1), .RX_STATUS(st1),
        .RX_COUNT(cnt1), .OVERRUN(ovr1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (rd0 && st0) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL mon0_unexpected actual=%0h required=none", {d0, perr0, ferr0});
            end else begin
                e = q0.pop_front();
                chk("mon0_entry", 32'({d0, perr0, ferr0}), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (rd1 && st1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL mon1_unexpected actual=%0h required=none", {d1, perr1, ferr1});
            end else begin
                e = q1.pop_front();
                chk("mon1_entry", 32'({1'b0, d1, perr1, ferr1}), 32'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    // par < 0: no parity bit; otherwise par[0] is the parity bit driven.
    task automatic send(input int sel, input logic [7:0] d, input int nbits,
                        input int par, input logic stp, input bit hold);
        drive(sel, 1'b0);
        tick(DIV);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, d[i]);
            tick(DIV);
        end
        if (par >= 0) begin
            drive(sel, par[0]);
            tick(DIV);
        end
        drive(sel, stp);
        tick(DIV);
        if (!hold) drive(sel, 1'b1);
        tick(4);
    endtask

    task automatic rd(input int sel);
        if (sel == 0) begin
            chk("rd0_status", 32'(st0), 32'd1);
            rd0 = 1'b1; tick(1); rd0 = 1'b0;
        end else begin
            chk("rd1_status", 32'(st1), 32'd1);
            rd1 = 1'b1; tick(1); rd1 = 1'b0;
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_data"},  32'(d0),    32'd0);
        chk({name, "_perr"},  32'(perr0), 32'd0);
        chk({name, "_ferr"},  32'(ferr0), 32'd0);
        chk({name, "_stat"},  32'(st0),   32'd0);
        chk({name, "_count"}, 32'(cnt0),  32'd0);
        chk({name, "_ovr"},   32'(ovr0),  32'd0);
    endtask

    initial begin
        reset = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1; rd0 = 1'b0; rd1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        tick(3);
        chk_reset_vals("reset");
        chk("reset_stat1", 32'(st1), 32'd0);
        reset = 1'b0;
        tick(2);

        // Basic frame then pop
        q0.push_back({8'hA5, 1'b0, 1'b0});
        send(0, 8'hA5, 8, -1, 1'b1, 1'b0);
        chk("t1_stat",  32'(st0),  32'd1);
        chk("t1_count", 32'(cnt0), 32'd1);
        chk("t1_data",  32'(d0),   32'hA5);
        chk("t1_flags", 32'({perr0, ferr0}), 32'd0);
        rd(0);
        chk("t1_empty_stat", 32'(st0), 32'd0);
        chk("t1_empty_data", 32'(d0),  32'd0);

        // Start-bit glitch is rejected
        rx0 = 1'b0; tick(4); rx0 = 1'b1;
        tick(3 * DIV);
        chk("t2_glitch_count", 32'(cnt0), 32'd0);
        q0.push_back({8'h3C, 1'b0, 1'b0});
        send(0, 8'h3C, 8, -1, 1'b1, 1'b0);
        chk("t2_count", 32'(cnt0), 32'd1);
        rd(0);
        chk("t2_drained", 32'(cnt0), 32'd0);

        // Even parity, 7 data bits: 0x07 has three ones, so parity bit must be 1
        q1.push_back({1'b0, 7'h07, 1'b1, 1'b0});
        send(1, 8'h07, 7, 0, 1'b1, 1'b0);
        chk("t3_perr_bad", 32'(perr1), 32'd1);
        rd(1);
        q1.push_back({1'b0, 7'h07, 1'b0, 1'b0});
        send(1, 8'h07, 7, 1, 1'b1, 1'b0);
        chk("t3_perr_ok", 32'(perr1), 32'd0);
        rd(1);

        // Framing error followed by a break
        q0.push_back({8'h81, 1'b0, 1'b1});
        send(0, 8'h81, 8, -1, 1'b0, 1'b1);
        tick(3 * DIV);
        rx0 = 1'b1;
        tick(4);
        chk("t4_break_count", 32'(cnt0),  32'd1);
        chk("t4_ferr",        32'(ferr0), 32'd1);
        q0.push_back({8'h55, 1'b0, 1'b0});
        send(0, 8'h55, 8, -1, 1'b1, 1'b0);
        chk("t4_count", 32'(cnt0), 32'd2);
        rd(0);
        rd(0);

        // Overrun, then simultaneous push/pop when full
        for (int v = 1; v <= 4; v++) begin
            q0.push_back({8'(v), 1'b0, 1'b0});
            send(0, 8'(v), 8, -1, 1'b1, 1'b0);
        end
        chk("t5_full_count", 32'(cnt0), 32'd4);
        chk("t5_ovr_pre",    32'(ovr0), 32'd0);
        send(0, 8'h05, 8, -1, 1'b1, 1'b0);
        chk("t5_ovr",        32'(ovr0), 32'd1);
        chk("t5_ovr_count",  32'(cnt0), 32'd4);
        for (int i = 0; i < 4; i++) rd(0);
        chk("t5_drained", 32'(cnt0), 32'd0);
        for (int v = 8'h11; v <= 8'h14; v++) begin
            q0.push_back({8'(v), 1'b0, 1'b0});
            send(0, 8'(v), 8, -1, 1'b1, 1'b0);
        end
        chk("t5_refill_count", 32'(cnt0), 32'd4);
        q0.push_back({8'h06, 1'b0, 1'b0});
        fork
            send(0, 8'h06, 8, -1, 1'b1, 1'b0);
            begin
                // Push lands on the 157th edge after the start bit is driven.
                repeat (156) @(posedge clk);
                #1 rd0 = 1'b1;
                @(posedge clk);
                #1 rd0 = 1'b0;
            end
        join
        chk("t5_pushpop_count", 32'(cnt0), 32'd4);
        chk("t5_ovr_sticky",    32'(ovr0), 32'd1);
        clr0 = 1'b1; tick(1); clr0 = 1'b0;
        chk("t5_ovr_clr", 32'(ovr0), 32'd0);
        for (int i = 0; i < 4; i++) rd(0);
        chk("t5_final_empty", 32'(cnt0), 32'd0);

        // Reset in the middle of a frame with one entry queued
        q0.push_back({8'h11, 1'b0, 1'b0});
        send(0, 8'h11, 8, -1, 1'b1, 1'b0);
        chk("t6_queued", 32'(cnt0), 32'd1);
        fork
            send(0, 8'hF0, 8, -1, 1'b1, 1'b0);
            begin
                repeat (5 * DIV + 8) @(posedge clk);
                #1 reset = 1'b1;
                #1 chk_reset_vals("t6_midreset");
            end
        join
        q0.delete();
        q1.delete();
        tick(1);
        reset = 1'b0;
        tick(2);
        chk_reset_vals("t6_after");
        q0.push_back({8'h5A, 1'b0, 1'b0});
        send(0, 8'h5A, 8, -1, 1'b1, 1'b0);
        chk("t6_count", 32'(cnt0), 32'd1);
        rd(0);
        chk("t6_empty", 32'(cnt0), 32'd0);

        chk("q0_left", 32'(q0.size()), 32'd0);
        chk("q1_left", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
